// File: rtl/keyed_mux_bank.sv
// Bank of key-locked muxes: a serially loaded key selects one candidate per channel; outputs stay 0 until a key is accepted.
// Build option: define KEYMUX_ALLOW_CHECK_EN to also reject keys containing a channel code not set in ALLOW_MASK.
module keyed_mux_bank #(
    parameter int CH = 4,
    parameter int SEL_W = 2,
    parameter logic [(1<<SEL_W)-1:0] ALLOW_MASK = 4'b1001
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_in,
    input  logic                      key_vld,
    input  logic                      key_done,
    input  logic [CH*(1<<SEL_W)-1:0]  data_in,
    output logic [CH-1:0]             data_out,
    output logic                      unlocked,
    output logic                      key_err
);
    localparam int NC = 1 << SEL_W;
    localparam int KW = CH * SEL_W;
    localparam int CW = $clog2(KW + 2);

    // state    | meaning
    // LOCKED   | no key yet, outputs 0
    // SHIFT    | key bits arriving
    // ACTIVE   | key accepted, muxes live
    // ERROR    | last key rejected, outputs 0
    typedef enum logic [1:0] {ST_LOCKED, ST_SHIFT, ST_ACTIVE, ST_ERROR} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   key_sr_q, key_sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            key_err_q, key_err_d;
    logic [CH-1:0]   data_q, data_d;
    logic [KW-1:0]   key_shift;
    logic            fields_ok;
    logic [NC-1:0]   cand;

    // Next key/count are resolved first so a key_done in the same cycle checks the updated values.
    always_comb begin
        key_shift         = key_sr_q >> 1;
        key_shift[KW-1]   = key_in;
        key_sr_d          = key_sr_q;
        cnt_d             = cnt_q;
        if (key_vld) begin
            key_sr_d = key_shift;
            if (state_q != ST_SHIFT)
                cnt_d = CW'(1);
            else if (cnt_q != CW'(KW + 1))
                cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef KEYMUX_ALLOW_CHECK_EN
    always_comb begin
        fields_ok = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (!ALLOW_MASK[key_sr_d[c*SEL_W +: SEL_W]])
                fields_ok = 1'b0;
        end
    end
`else
    assign fields_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        key_err_d = key_err_q;
        if (key_vld) begin
            state_d   = ST_SHIFT;
            key_err_d = 1'b0;
        end
        if (state_q == ST_SHIFT && key_done) begin
            if (cnt_d == CW'(KW) && fields_ok) begin
                state_d = ST_ACTIVE;
            end else begin
                state_d   = ST_ERROR;
                key_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        data_d = '0;
        cand   = '0;
        if (state_q == ST_ACTIVE) begin
            for (int c = 0; c < CH; c++) begin
                cand      = data_in[c*NC +: NC];
                data_d[c] = cand[key_sr_q[c*SEL_W +: SEL_W]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOCKED;
            key_sr_q  <= '0;
            cnt_q     <= '0;
            key_err_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            key_sr_q  <= key_sr_d;
            cnt_q     <= cnt_d;
            key_err_q <= key_err_d;
            data_q    <= data_d;
        end
    end

    assign data_out = data_q;
    assign unlocked = (state_q == ST_ACTIVE);
    assign key_err  = key_err_q;
endmodule

// File: tb/tb_keyed_mux_bank.sv
// Scoreboard bench for keyed_mux_bank: driver updates a key-list reference model and queues expected outputs; a monitor compares each cycle.
module tb_keyed_mux_bank;
    localparam int CH = 4;
    localparam int SEL_W = 2;
    localparam int NC = 4;
    localparam int KW = 8;
    localparam logic [3:0] ALLOW = 4'b1001;

    logic clk = 1'b0;
    logic rst;
    logic key_in, key_vld, key_done;
    logic [15:0] data_in;
    logic [3:0]  data_out;
    logic unlocked, key_err;

    logic k1_in, k1_vld, k1_done;
    logic [1:0] d1_in;
    logic d1_out, u1, e1;

    keyed_mux_bank #(.CH(CH), .SEL_W(SEL_W), .ALLOW_MASK(ALLOW)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_vld(key_vld), .key_done(key_done),
        .data_in(data_in), .data_out(data_out), .unlocked(unlocked), .key_err(key_err));

    keyed_mux_bank #(.CH(1), .SEL_W(1), .ALLOW_MASK(2'b11)) dut1 (
        .clk(clk), .rst(rst), .key_in(k1_in), .key_vld(k1_vld), .key_done(k1_done),
        .data_in(d1_in), .data_out(d1_out), .unlocked(u1), .key_err(e1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       unl;
        logic       err;
        logic [3:0] dat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: 0 locked, 1 loading, 2 active, 3 error; key kept as the list of bits received.
    int         m_mode = 0;
    bit         m_bits[$];
    logic [7:0] m_key = '0;
    bit         m_err = 0;
    logic [3:0] allow_v = ALLOW;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        int   prev;
        int   fld;
        bit   ok;
        e.dat = '0;
        if (m_mode == 2) begin
            for (int c = 0; c < CH; c++) begin
                fld = int'((m_key >> (c*SEL_W)) % NC);
                e.dat[c] = data_in[c*NC + fld];
            end
        end
        prev = m_mode;
        if (key_vld) begin
            if (prev != 1) m_bits.delete();
            if (m_bits.size() <= KW) m_bits.push_back(key_in);
            m_err  = 0;
            m_mode = 1;
        end
        if (key_done && prev == 1) begin
            ok = (m_bits.size() == KW);
            if (ok) begin
                m_key = '0;
                for (int i = 0; i < KW; i++) m_key[i] = m_bits[i];
            end
`ifdef KEYMUX_ALLOW_CHECK_EN
            if (ok) begin
                for (int c = 0; c < CH; c++) begin
                    fld = int'((m_key >> (c*SEL_W)) % NC);
                    if (!allow_v[fld]) ok = 0;
                end
            end
`endif
            if (ok) m_mode = 2;
            else begin
                m_mode = 3;
                m_err  = 1;
            end
        end
        e.unl = (m_mode == 2);
        e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic b, input logic d, input logic [15:0] dat);
        key_vld  = v;
        key_in   = b;
        key_done = d;
        data_in  = dat;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic send_key(input logic [7:0] k, input int first, input int n, input logic dwl);
        for (int i = first; i < n; i++)
            step(1'b1, (i < KW) ? k[i] : 1'b1, dwl && (i == n - 1), 16'($urandom));
        if (!dwl) step(1'b0, 1'b0, 1'b1, 16'($urandom));
    endtask

    task automatic wait_drain();
        int b = 0;
        while (sb.size() > 0 && b < 10) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        wait_drain();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_unlocked", 32'(unlocked), 0);
        chk("rst_key_err", 32'(key_err), 0);
        chk("rst_small_unlocked", 32'(u1), 0);
        m_mode = 0;
        m_err  = 0;
        m_bits.delete();
        key_vld = 1'b0; key_done = 1'b0; key_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("unlocked", 32'(unlocked), 32'(e.unl));
                chk("key_err", 32'(key_err), 32'(e.err));
                chk("data_out", 32'(data_out), 32'(e.dat));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [7:0] k;
        int nb;
        int r;
        rst = 1'b1;
        key_in = 1'b0; key_vld = 1'b0; key_done = 1'b0; data_in = '0;
        k1_in = 1'b0; k1_vld = 1'b0; k1_done = 1'b0; d1_in = 2'b10;
        #1;
        chk("init_data_out", 32'(data_out), 0);
        chk("init_unlocked", 32'(unlocked), 0);
        chk("init_key_err", 32'(key_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fields 3,0,0,3 pick bits 3 and 15 of 16'h8008.
        send_key(8'hC3, 0, 8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h8008);
        step(1'b0, 1'b0, 1'b0, 16'h8008);
        idle(2);

        send_key(8'hC6, 0, 8, 1'b0);
        idle(2);
        send_key(8'hC3, 0, 7, 1'b0);
        idle(2);
        send_key(8'hC3, 0, 9, 1'b0);
        idle(2);

        // Restart from ACTIVE: the pulsed bit is bit 0 of the next key.
        send_key(8'hC3, 0, 8, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 16'($urandom));
        idle(2);
        send_key(8'h3C, 1, 8, 1'b1);
        idle(3);

        send_key(8'hC3, 0, 4, 1'b1);
        do_reset();
        send_key(8'hC3, 0, 8, 1'b0);
        idle(3);
        send_key(8'hFF, 0, 8, 1'b0);
        idle(2);
        do_reset();

        // One-bit key bank alongside the main bench traffic.
        k1_vld = 1'b1; k1_in = 1'b1; k1_done = 1'b1;
        idle(1);
        chk("k1_done_ignored_locked", 32'(u1), 0);
        k1_vld = 1'b0;
        idle(1);
        chk("k1_unlock", 32'(u1), 1);
        k1_done = 1'b0;
        idle(1);
        chk("k1_data_key1", 32'(d1_out), 1);
        k1_vld = 1'b1; k1_in = 1'b0; k1_done = 1'b1;
        idle(1);
        chk("k1_restart", 32'(u1), 0);
        k1_vld = 1'b0;
        idle(1);
        chk("k1_unlock_key0", 32'(u1), 1);
        k1_done = 1'b0;
        idle(1);
        chk("k1_data_key0", 32'(d1_out), 0);
        k1_vld = 1'b1; k1_in = 1'b1;
        idle(1);
        k1_done = 1'b1;
        idle(1);
        chk("k1_overlength_err", 32'(e1), 1);
        chk("k1_overlength_locked", 32'(u1), 0);
        k1_vld = 1'b0; k1_done = 1'b0;

        for (int it = 0; it < 250; it++) begin
            k = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                for (int c = 0; c < CH; c++)
                    k[c*SEL_W +: SEL_W] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            end
            r  = int'($urandom_range(0, 9));
            nb = (r == 0) ? 7 : (r == 1) ? 9 : (r == 2) ? 3 : KW;
            if (r == 2) begin
                send_key(k, 0, nb, 1'b1);
                do_reset();
            end else begin
                send_key(k, 0, nb, $urandom_range(0, 1) == 1);
            end
            for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                step(1'b0, 1'b0, $urandom_range(0, 3) == 0, 16'($urandom));
            if ($urandom_range(0, 24) == 0) do_reset();
        end

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
